blake2b_msg_packer: RTL
=======================

// Module: blake2b_msg_packer
// PURPOSE
// Upstream feeder for the BLAKE2b compression core. Packs a 64-bit little-endian message stream into 128-byte blocks.
// Tracks the running byte offset t. Flags the final block (f0) and zero-pads its unused bytes.
// Hands one block at a time to the core, which applies blake2_pkg IV/SIGMA per block.
// PARAMETERS
// T_BITS  128  width of byte-offset counter o_t; wraps mod 2^T_BITS
// PORTS
// i_clk    in   1     clock
// i_rst    in   1     synchronous active-high reset
// i_dat    in   64    message word; byte 0 in [7:0]
// i_keep   in   8     valid-byte mask; all-ones unless i_eop; on i_eop contiguous from bit 0
// i_eop    in   1     last word of message
// i_val    in   1     input beat valid
// o_rdy    out  1     packer accepts input beat
// o_block  out  1024  m[0..15]; m[k] in [64k+63:64k]
// o_t      out  T_BITS  total message bytes consumed up to and including this block
// o_last   out  1     final block of message (core sets f0 = all ones)
// o_val    out  1     block valid
// i_rdy    in   1     core accepts block
// BEHAVIOUR
// - Reset values: o_rdy=1, o_val=0, o_last=0, o_t=0, o_block=0.
//   Internal state: word index=0, byte counter=0, state FILL.
// - Input handshake: a beat is accepted when i_val && o_rdy. Output handshake: o_val && i_rdy.
// - FILL state (o_rdy=1):
//   - Accepted beat: write (i_dat & byte-mask(i_keep)) into word slot idx. Add popcount(i_keep) to the byte counter.
//   - Increment idx.
//   - Go to OUT when idx==15 or i_eop. o_val rises the cycle after that beat (latency 1).
// - OUT state: o_rdy=0, o_val=1, and o_block/o_t/o_last are held stable until the handshake.
//   - On handshake: clear the buffer to zero, set idx=0, return to FILL.
//   - Byte counter persists across blocks. It clears only after a block with o_last=1 is taken.
// - o_last=1 iff the block was closed by i_eop. A non-eop 16th word closes the block with o_last=0.
// - Empty message: a single beat with i_eop=1 and i_keep=0.
//   Emits an all-zero block with o_t=0 (relative to message start) and o_last=1.
//   i_keep=0 is legal only as the first word of a message. Otherwise the result is undefined; a bench assertion flags it.
// - Message length a multiple of 128: i_eop arrives on word 15, so that block is last. No extra padding block is produced.
// - Partial last block: slots after the eop word stay zero. Bytes above i_keep in the eop word are zeroed.
// - Counter arithmetic: unsigned, modulo 2^T_BITS; wraps silently.
// - i_val while o_rdy=0: the beat is not consumed, and the source holds it.
// - Reset mid-block or in OUT: any partial block is discarded and all state returns to reset values next cycle.
// - Throughput: 16 input cycles + 1 output cycle minimum per full block.
//   No input is accepted in the same cycle as the output handshake.
// STRUCTURE
// - Add to blake2_pkg:
//   - localparams BLOCK_BYTES=128, BLOCK_WORDS=16.
//   - typedef logic [15:0][63:0] blake2_block_t.
//   - function keep_to_mask(logic [7:0]) -> logic [63:0].
//   - function keep_popcnt(logic [7:0]) -> logic [3:0].
// - Two-state enum {FILL, OUT} local to the module.
// - No sub-module; buffer, index and counter are plain flops.
// TESTING
// 1. Empty message: one beat, i_keep=0, i_eop=1 -> one block, o_block=0, o_t=0, o_last=1.
// 2. "abc": i_dat=64'h0000_0000_0063_6261, keep=8'h07, eop -> m[0]=64'h636261, m[1..15]=0, o_t=3, o_last=1.
// 3. 128 bytes (16 full words, eop on word 15) -> exactly one block, o_t=128, o_last=1.
// 4. 129 bytes (17th word keep=8'h01, data 8'hAB) -> block1: o_t=128, o_last=0. block2: m[0]=64'hAB, o_t=129, o_last=1.
// 5. Backpressure: i_rdy low 5 cycles in OUT -> o_val held, o_block/o_t stable, o_rdy=0, no input beats consumed.
// 6. Reset: assert i_rst after word 7 -> o_val=0 next cycle; a fresh "abc" then gives o_t=3.
//    With T_BITS=8, a 3-block message wraps o_t to 128, 0, then the final count mod 256.

Source files
------------

// File: rtl/blake2_pkg.sv
// Shared BLAKE2b constants, block type and byte-lane helpers used by the
// message packer feeding the compression core.
package blake2_pkg;

    localparam int BLOCK_BYTES = 128;
    localparam int BLOCK_WORDS = 16;
    localparam int WORD_BYTES  = 8;

    typedef logic [15:0][63:0] blake2_block_t;

    // Expand a per-byte valid mask into a 64-bit data mask.
    function automatic logic [63:0] keep_to_mask(input logic [7:0] keep);
        logic [63:0] mask;
        mask = '0;
        for (int b = 0; b < WORD_BYTES; b++) begin
            mask[8*b +: 8] = {8{keep[b]}};
        end
        return mask;
    endfunction

    function automatic logic [3:0] keep_popcnt(input logic [7:0] keep);
        logic [3:0] cnt;
        cnt = '0;
        for (int b = 0; b < WORD_BYTES; b++) begin
            cnt = cnt + {3'b000, keep[b]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/blake2b_msg_packer.sv
// Packs a 64-bit little-endian message stream into 128-byte BLAKE2b blocks,
// tracking the running byte offset t and flagging the final block.
module blake2b_msg_packer
    import blake2_pkg::*;
#(
    parameter int T_BITS = 128
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [63:0]         i_dat,
    input  logic [7:0]          i_keep,
    input  logic                i_eop,
    input  logic                i_val,
    output logic                o_rdy,
    output logic [1023:0]       o_block,
    output logic [T_BITS-1:0]   o_t,
    output logic                o_last,
    output logic                o_val,
    input  logic                i_rdy
);

    typedef enum logic {
        FILL = 1'b0,
        OUT  = 1'b1
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(BLOCK_WORDS - 1);

    state_t              state_q;
    state_t              state_d;
    blake2_block_t       buf_q;
    logic [3:0]          idx_q;
    logic [T_BITS-1:0]   cnt_q;
    logic                last_q;
    logic                beat_acc;
    logic                blk_acc;

    // NOTE: next-state logic is combinational, so every output gets a default
    // before the case; a missing default on any path would infer a latch.
    always_comb begin
        state_d  = state_q;
        beat_acc = 1'b0;
        blk_acc  = 1'b0;
        o_rdy    = 1'b0;
        o_val    = 1'b0;
        case (state_q)
            FILL: begin
                o_rdy    = 1'b1;
                beat_acc = i_val;
                if (beat_acc && (idx_q == LAST_IDX || i_eop)) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                o_val   = 1'b1;
                blk_acc = i_rdy;
                if (blk_acc) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the block buffer is reset despite its width because o_block has a
    // defined all-zero reset value and partial blocks must not leak across resets.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            buf_q  <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else if (beat_acc) begin
            buf_q[idx_q] <= i_dat & keep_to_mask(i_keep);
            idx_q        <= idx_q + 4'd1;
            cnt_q        <= cnt_q + T_BITS'(keep_popcnt(i_keep));
            last_q       <= i_eop;
        end else if (blk_acc) begin
            buf_q  <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
            // The offset spans the whole message; only a finished message restarts it.
            if (last_q) begin
                cnt_q <= '0;
            end
        end
    end

    assign o_block = buf_q;
    assign o_t     = cnt_q;
    assign o_last  = last_q;

endmodule
